adc_bcd_scaler: RTL



---
 rtl/adc_bcd_scaler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_bcd_scaler.sv
// ADC display pre-processor: averages a power-of-two window of samples,
// scales the average to millivolts, and on a periodic tick converts the
// result to packed BCD with a sequential double-dabble. It also flags
// leading-zero digits for blanking and reports display overflow.
module adc_bcd_scaler #(
  parameter int ADC_W    = 8,
  parameter int FS_MV    = 2500,
  parameter int DIGITS   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int T_UPDATE = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [ADC_W-1:0]      sample_data,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  bcd_valid,
  output logic                  overflow
);

  localparam int MV_W     = $clog2(FS_MV + 1);
  localparam int ACC_W    = ADC_W + AVG_LOG2;
  localparam int CNT_W    = AVG_LOG2 + 1;
  localparam int BCD_W    = 4 * DIGITS;
  localparam int PROD_W   = ADC_W + MV_W;
  localparam int TCK_W    = (T_UPDATE > 1) ? $clog2(T_UPDATE) : 1;
  localparam int STEP_W   = $clog2(MV_W + 1);
  localparam int MAX_DISP = (10 ** DIGITS) - 1;
  localparam int WIN_LAST = (2 ** AVG_LOG2) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Floor-scaled millivolts, clamped to the largest displayable value.
  // Returns {ovf, mv}.
  function automatic logic [MV_W:0] sat_mv(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] q;
    q = p >> ADC_W;
    if (32'(q) > 32'(MAX_DISP)) begin
      return {1'b1, MV_W'(MAX_DISP)};
    end
    return {1'b0, q[MV_W-1:0]};
  endfunction

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in b.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] w,
                                               input logic b);
    logic [BCD_W-1:0] a;
    a = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return {a[BCD_W-2:0], b};
  endfunction

  // A digit is blanked when it and every more significant digit are zero;
  // the units digit always stays lit.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] b);
    logic              all_z;
    logic [DIGITS-1:0] m;
    m     = '0;
    all_z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_z = all_z & (b[4*i +: 4] == 4'd0);
      m[i]  = all_z;
    end
    return m;
  endfunction

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADC_W-1:0]  r_hold;
  logic [TCK_W-1:0]  r_tick_cnt;
  state_t            r_state;
  state_t            w_state_next;
  logic [ADC_W-1:0]  r_cap;
  logic [MV_W-1:0]   r_mv;
  logic              r_ovf;
  logic [BCD_W-1:0]  r_work;
  logic [STEP_W-1:0] r_step;
  logic [BCD_W-1:0]  r_bcd;
  logic [DIGITS-1:0] r_blank;
  logic              r_ovf_out;
  logic              r_valid;

  logic [ACC_W-1:0]  w_sum;
  logic              w_win_done;
  logic              w_tick;
  logic              w_last_step;
  logic [PROD_W-1:0] w_prod;
  logic [MV_W:0]     w_sat;
  logic [BCD_W-1:0]  w_work_next;

  assign w_sum       = r_acc + ACC_W'(sample_data);
  assign w_win_done  = sample_valid && (r_cnt == CNT_W'(WIN_LAST));
  assign w_tick      = (r_tick_cnt == TCK_W'(T_UPDATE - 1));
  assign w_last_step = (r_step == STEP_W'(MV_W - 1));
  assign w_prod      = PROD_W'(r_cap) * PROD_W'(FS_MV);
  assign w_sat       = sat_mv(w_prod);
  assign w_work_next = dd_step(r_work, r_mv[MV_W-1]);

  // Window accumulator: latch the floor average when the window fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else if (sample_valid) begin
      if (w_win_done) begin
        r_hold <= w_sum[ACC_W-1:AVG_LOG2];
        r_acc  <= '0;
        r_cnt  <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Free-running update tick counter; never stalls for the converter.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TCK_W'(1);
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Converter sequencing; ticks outside IDLE are dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_next = MULT;
      MULT:    w_state_next = CONV;
      CONV:    if (w_last_step) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Converter datapath; outputs load on the final shift so they are
  // visible together with the bcd_valid pulse in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap     <= '0;
      r_mv      <= '0;
      r_ovf     <= 1'b0;
      r_work    <= '0;
      r_step    <= '0;
      r_bcd     <= '0;
      r_blank   <= blank_of('0);
      r_ovf_out <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) r_cap <= r_hold;
        end
        MULT: begin
          r_ovf  <= w_sat[MV_W];
          r_mv   <= w_sat[MV_W-1:0];
          r_work <= '0;
          r_step <= '0;
        end
        CONV: begin
          r_work <= w_work_next;
          r_mv   <= r_mv << 1;
          r_step <= r_step + STEP_W'(1);
          if (w_last_step) begin
            r_bcd     <= w_work_next;
            r_blank   <= blank_of(w_work_next);
            r_ovf_out <= r_ovf;
            r_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd        = r_bcd;
  assign blank_mask = r_blank;
  assign bcd_valid  = r_valid;
  assign overflow   = r_ovf_out;

endmodule
